ssd_refresh_sched: RTL

Refresh scheduler and two-source arbiter for the dual-digit Pmod SSD.
- Time-multiplexes the two digits with a programmable dwell time, inserting an all-segments-off blanking gap at every digit switch to prevent ghosting.
- Applies 8-level PWM brightness.
- Shares one display value between two requesters (CPU bus bridge, hardware status source) via a round-robin arbitrated shadow register.
- Value changes take effect only at frame boundaries, so no digit pair is ever torn.

---
 rtl/ssd_refresh_sched.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/ssd_refresh_sched.sv
// Dual-digit seven-segment refresh scheduler with blanking gaps, 8-level PWM,
// and a round-robin arbitrated shadow register updated only at frame boundaries.
module ssd_refresh_sched #(
    parameter int DWELL_CYCLES = 3000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_valid,
    input  logic [7:0] a_data,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic [7:0] b_data,
    output logic       b_ready,
    input  logic [2:0] bri,
    output logic [6:0] seg,
    output logic       digit_sel,
    output logic       blank,
    output logic [7:0] cur_value
);

    localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    // At least 3 bits so the PWM phase can always be taken from the low bits.
    localparam int CW   = (MAXC > 8) ? $clog2(MAXC) : 3;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            dsel_nxt;
    logic [7:0]      val_nxt;
    logic [6:0]      seg_nxt;
    logic [3:0]      nibble;
    logic            frame_load;

    logic [7:0]      shadow;
    logic            full;
    logic            last_grant_b;
    logic            a_acc, b_acc;

    function automatic logic [6:0] font(input logic [3:0] n);
        case (n)
            4'h0: font = 7'b1111110;
            4'h1: font = 7'b0110000;
            4'h2: font = 7'b1101101;
            4'h3: font = 7'b1111001;
            4'h4: font = 7'b0110011;
            4'h5: font = 7'b1011011;
            4'h6: font = 7'b1011111;
            4'h7: font = 7'b1110000;
            4'h8: font = 7'b1111111;
            4'h9: font = 7'b1111011;
            4'hA: font = 7'b1110111;
            4'hB: font = 7'b0011111;
            4'hC: font = 7'b1001110;
            4'hD: font = 7'b0111101;
            4'hE: font = 7'b1001111;
            default: font = 7'b1000111;
        endcase
    endfunction

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt + CW'(1);
        dsel_nxt   = digit_sel;
        val_nxt    = cur_value;
        frame_load = 1'b0;
        case (state)
            ST_BLANK: begin
                if (cnt == CW'(BLANK_CYCLES - 1)) begin
                    state_nxt = ST_SHOW;
                    cnt_nxt   = '0;
                    dsel_nxt  = ~digit_sel;
                    // Switching to the low digit starts a new frame.
                    if (digit_sel && full) begin
                        val_nxt    = shadow;
                        frame_load = 1'b1;
                    end
                end
            end
            default: begin
                if (cnt == CW'(DWELL_CYCLES - 1)) begin
                    state_nxt = ST_BLANK;
                    cnt_nxt   = '0;
                end
            end
        endcase

        nibble  = dsel_nxt ? val_nxt[7:4] : val_nxt[3:0];
        seg_nxt = 7'b0;
        if (state_nxt == ST_SHOW && cnt_nxt[2:0] <= bri)
            seg_nxt = font(nibble);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_BLANK;
            cnt       <= '0;
            digit_sel <= 1'b1;
            seg       <= 7'b0;
            blank     <= 1'b1;
            cur_value <= 8'h00;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            digit_sel <= dsel_nxt;
            seg       <= seg_nxt;
            blank     <= (state_nxt == ST_BLANK);
            cur_value <= val_nxt;
        end
    end

    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!reset && !full) begin
            if (a_valid && b_valid) begin
                a_ready = last_grant_b;
                b_ready = ~last_grant_b;
            end else if (a_valid) begin
                a_ready = 1'b1;
            end else if (b_valid) begin
                b_ready = 1'b1;
            end else begin
                a_ready = last_grant_b;
                b_ready = ~last_grant_b;
            end
        end
    end

    assign a_acc = a_valid && a_ready;
    assign b_acc = b_valid && b_ready;

    // Readies are gated by full, so an accept never coincides with a frame load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow       <= 8'h00;
            full         <= 1'b0;
            last_grant_b <= 1'b1;
        end else if (a_acc) begin
            shadow       <= a_data;
            full         <= 1'b1;
            last_grant_b <= 1'b0;
        end else if (b_acc) begin
            shadow       <= b_data;
            full         <= 1'b1;
            last_grant_b <= 1'b1;
        end else if (frame_load) begin
            full         <= 1'b0;
        end
    end

endmodule
